// File: rtl/dea_stream_ctrl.sv
// Job sequencer for the DEA core: reset, key load, then gated byte streaming
// into a small result FIFO so the core keystream never advances on a stall.
module dea_stream_ctrl #(
    parameter int KEY_BYTES  = 4,
    parameter int LEN_W      = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   dclk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LEN_W-1:0]       msg_len,
    input  logic [8*KEY_BYTES-1:0] key_in,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            cyc_count,
    output logic                   core_reset,
    output logic                   core_kset,
    output logic                   core_en,
    output logic [7:0]             core_din,
    input  logic [7:0]             core_dout
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_RST, S_KEY, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   state, state_nx;
    logic [8*KEY_BYTES-1:0]   key_q;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         issued;
    logic [KW-1:0]            kcnt;
    logic                     pending;
    logic [7:0]               mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count;
    logic [CW:0]              occ;
    logic                     issue, pop, drain_empty;

    // Occupancy counts the byte still inside the core so the FIFO can never overflow.
    assign occ         = {1'b0, count} + {{CW{1'b0}}, pending};
    assign in_ready    = (state == S_RUN) && (issued < len_q) && (occ < (CW+1)'(FIFO_DEPTH));
    assign issue       = in_valid && in_ready;
    assign out_valid   = (count != '0);
    assign out_data    = mem[rd_ptr];
    assign pop         = out_valid && out_ready;
    assign drain_empty = !pending && ((count == '0) || ((count == CW'(1)) && pop));

    always_comb begin
        state_nx = state;
        core_en  = 1'b0;
        core_din = 8'h00;
        case (state)
            S_IDLE:  if (start) state_nx = S_RST;
            S_RST: begin
                core_en  = 1'b1;
                state_nx = S_KEY;
            end
            S_KEY: begin
                core_en  = 1'b1;
                core_din = key_q[{kcnt, 3'b000} +: 8];
                if (kcnt == KW'(KEY_BYTES-1))
                    state_nx = (len_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (issue) begin
                    core_en  = 1'b1;
                    core_din = in_data;
                    if ((issued + LEN_W'(1)) == len_q) state_nx = S_DRAIN;
                end
            end
            S_DRAIN: if (drain_empty) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge dclk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            core_reset <= 1'b1;
            core_kset  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            // Core stays held in reset whenever no job is running.
            core_reset <= (state_nx == S_IDLE) || (state_nx == S_RST);
            core_kset  <= (state_nx == S_KEY);
            busy       <= (state_nx != S_IDLE);
            done       <= (state_nx == S_DONE);
        end
    end

    always_ff @(posedge dclk or negedge reset) begin
        if (!reset) begin
            key_q     <= '0;
            len_q     <= '0;
            issued    <= '0;
            kcnt      <= '0;
            pending   <= 1'b0;
            cyc_count <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                key_q     <= key_in;
                len_q     <= msg_len;
                issued    <= '0;
                cyc_count <= '0;
            end else if (state != S_IDLE) begin
                cyc_count <= cyc_count + 32'd1;
            end
            kcnt    <= (state == S_KEY) ? kcnt + KW'(1) : '0;
            pending <= issue;
            if (issue) issued <= issued + LEN_W'(1);
        end
    end

    // Result FIFO: the core output is captured one cycle after each issue.
    always_ff @(posedge dclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pending) begin
                mem[wr_ptr] <= core_dout;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({pending, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dea_stream_ctrl.sv
// Directed bench for dea_stream_ctrl with a small keyed-XOR core model.
module tb_dea_stream_ctrl;
    localparam int KB = 4;
    localparam int LW = 24;
    localparam int FD = 4;

    logic            dclk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [LW-1:0]   msg_len = '0;
    logic [8*KB-1:0] key_in = '0;
    logic            in_valid = 1'b0;
    logic [7:0]      in_data = 8'h00;
    logic            in_ready, out_valid, busy, done;
    logic [7:0]      out_data, core_din;
    logic            out_ready = 1'b0;
    logic [31:0]     cyc_count;
    logic            core_reset, core_kset, core_en;
    logic [7:0]      core_dout = 8'h00;
    logic [7:0]      core_key = 8'h00;

    int nchk = 0;
    int nerr = 0;

    dea_stream_ctrl #(.KEY_BYTES(KB), .LEN_W(LW), .FIFO_DEPTH(FD)) dut (
        .dclk(dclk), .reset(reset), .start(start), .msg_len(msg_len), .key_in(key_in),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .cyc_count(cyc_count),
        .core_reset(core_reset), .core_kset(core_kset), .core_en(core_en),
        .core_din(core_din), .core_dout(core_dout)
    );

    always #5 dclk = ~dclk;

    // Core model: last key byte loaded becomes the XOR pad; holds when not enabled.
    always @(posedge dclk) begin
        if (core_en) begin
            if (core_reset) begin
                core_key  <= 8'h00;
                core_dout <= 8'h00;
            end else if (core_kset) begin
                core_key <= core_din;
            end else begin
                core_dout <= core_din ^ core_key;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_core_reset", core_reset, 1);
        chk("rst_in_ready",   in_ready,   0);
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_busy",       busy,       0);
        chk("rst_done",       done,       0);
        chk("rst_core_kset",  core_kset,  0);
        chk("rst_core_en",    core_en,    0);
        chk("rst_core_din",   core_din,   0);
        chk("rst_out_data",   out_data,   0);
        chk("rst_cyc_count",  cyc_count,  0);
    endtask

    // One job: vmode 0 = in_valid held, 1 = toggles; stall window st_lo..st_hi;
    // sb_cyc = cycle of a spurious start; exp_done/exp_maxbuf < 0 means unchecked.
    task automatic run_job(input logic [31:0] key, input int n, input logic [7:0] base,
                           input int vmode, input int st_lo, input int st_hi,
                           input int sb_cyc, input int exp_done, input int exp_maxbuf);
        int         idx, pops, done_at, maxbuf, viol_en, viol_stab;
        logic [7:0] got [$];
        logic       prev_stall;
        logic [7:0] prev_data, e;
        idx = 0; pops = 0; done_at = -1; maxbuf = 0; viol_en = 0; viol_stab = 0;
        prev_stall = 1'b0; prev_data = 8'h00;
        @(posedge dclk); #1;
        start = 1'b1; key_in = key; msg_len = LW'(n);
        for (int c = 0; c < 300 && done_at < 0; c++) begin
            if (c > 0) begin
                @(posedge dclk); #1;
                start = (c == sb_cyc);
                if (c == sb_cyc) begin
                    key_in  = 32'h55555555;
                    msg_len = LW'(3);
                end
            end
            in_valid  = (idx < n) && (vmode == 0 || (c % 2) == 0);
            in_data   = base + 8'(idx);
            out_ready = !(c >= st_lo && c <= st_hi);
            #1;
            if (c == 1) chk("rst_pulse", core_reset, 1);
            if (c >= 2 && c < 2 + KB) begin
                chk("key_kset", core_kset, 1);
                chk("key_en", core_en, 1);
                chk("key_din", core_din, key[8*(c-2) +: 8]);
            end
            if (c >= KB + 2 && core_en !== (in_valid && in_ready)) viol_en++;
            if (prev_stall && (!out_valid || out_data !== prev_data)) viol_stab++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                pops++;
            end
            if (idx - pops > maxbuf) maxbuf = idx - pops;
            if (done) done_at = c;
        end
        in_valid = 1'b0;
        if (exp_done >= 0) chk("done_cycle", done_at, exp_done);
        else               chk("done_seen", done_at >= 0, 1);
        chk("n_out", got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            e = (base + 8'(i)) ^ key[31:24];
            chk("out_data", got[i], e);
        end
        chk("en_gate", viol_en, 0);
        chk("stall_hold", viol_stab, 0);
        if (exp_maxbuf >= 0) chk("max_buf", maxbuf, exp_maxbuf);
        @(posedge dclk); #2;
        if (exp_done >= 0) chk("cyc_count", cyc_count, exp_done);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        int idx;
        #2 reset = 1'b0;
        repeat (2) @(posedge dclk);
        #1 chk_reset_vals();
        reset = 1'b1;

        // Key load with empty message
        run_job(32'hAAAAAAAA, 0, 8'h00, 0, -1, -1, -1, 6, -1);
        // Full-rate stream
        run_job(32'hAAAAAAAA, 16, 8'h00, 0, -1, -1, -1, 24, -1);
        // Backpressure: out_ready low for 10 cycles mid-stream
        run_job(32'hAAAAAAAA, 16, 8'h00, 0, 9, 18, -1, -1, 4);
        // Input gaps with distinct key bytes (checks byte order)
        run_job(32'h44332211, 8, 8'h10, 1, -1, -1, -1, 23, -1);
        // Start while busy is ignored
        run_job(32'hAAAAAAAA, 6, 8'h20, 0, -1, -1, 8, 14, -1);

        // Reset mid-job with three results buffered
        idx = 0;
        @(posedge dclk); #1;
        start = 1'b1; key_in = 32'hAAAAAAAA; msg_len = LW'(16); out_ready = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge dclk); #1;
            start    = 1'b0;
            in_valid = (idx < 3);
            in_data  = 8'(idx);
            #1;
            if (in_valid && in_ready) idx++;
        end
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_data", out_data, 8'hAA);
        @(posedge dclk); #1;
        in_valid = 1'b0;
        reset    = 1'b0;
        #1 chk_reset_vals();
        @(posedge dclk); #1;
        reset = 1'b1;
        run_job(32'hAAAAAAAA, 4, 8'h30, 0, -1, -1, -1, 12, -1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
